ddr_cmd_sequencer: RTL and testbench
====================================

# ddr_cmd_sequencer

Controller-side command initiator for the bank-timing model. It accepts one read or write request at a time over a valid/ready handshake. It then emits the single-cycle command strobes (ACT, RD/RDA, WR/WRA, PR) with bank group, bank and address, honouring tRCD, burst length, write recovery and tRP. It is the transmitting end of the strobe interface consumed by TimingFSM and replaces hand-timed stimulus in system benches.

## Interface
Parameters:
- BGWIDTH, 2, bank-group address width (0 for DDR3)
- BAWIDTH, 2, bank address width
- ROWWIDTH, 16, row address width
- COLWIDTH, 10, column address width; ADDRWIDTH = max(ROWWIDTH, COLWIDTH)
- BL, 8, burst length in cycles (legal: 4, 8)
- T_RCD, 15, ACT-to-CAS cycles (≥1)
- T_WR, 12, write-recovery cycles after the last write burst cycle (≥0)
- T_RP, 15, PR-to-idle cycles (≥1)

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  sequencer can accept a request
- req_write  in  1  1 = write, 0 = read
- req_ap  in  1  auto-precharge (RDA/WRA instead of RD/WR + PR)
- req_bg  in  BGWIDTH  bank group
- req_ba  in  BAWIDTH  bank
- req_row  in  ROWWIDTH  row address
- req_col  in  COLWIDTH  column address
- bg  out  BGWIDTH  bank group for the current command
- ba  out  BAWIDTH  bank for the current command
- addr  out  ADDRWIDTH  row during ACT, column during CAS, 0 otherwise
- ACT, RD, RDA, WR, WRA, PR  out  1 each  one-cycle command strobes
- done  out  1  one-cycle pulse when a request fully retires

## Operation
- States: IDLE, ACT, WAIT_RCD, CAS, BURST, WAIT_WR, PRE, WAIT_RP.
- req_ready = (state == IDLE) && !reset. A handshake (req_valid && req_ready at a rising edge) captures all req_* fields into holding registers.
- IDLE → ACT on handshake. ACT asserts the ACT strobe with addr = row. Then WAIT_RCD for T_RCD−1 cycles, then CAS.
- CAS asserts exactly one of RD / RDA / WR / WRA, selected by req_write and req_ap, with addr = zero-extended column. BURST covers the remaining BL−1 cycles.
- After BURST:
  - Read without AP → PRE.
  - Write without AP → WAIT_WR for T_WR cycles, then PRE (direct to PRE if T_WR = 0).
  - With AP → the same path, but the PRE cycle issues no PR strobe (the bank self-precharges).
- PRE asserts PR (non-AP only), then WAIT_RP for T_RP−1 cycles, then IDLE. done pulses on the first IDLE cycle.
- bg/ba hold the captured values from the ACT cycle until return to IDLE, then 0.
- At most one strobe is high in any cycle. Strobes never assert outside their state.
- Requests presented while busy are ignored (req_ready = 0). req_* may change freely after capture.

## Timing
- All outputs are registered, except req_ready, which is decoded from state.
- Reset values: all strobes 0, done 0, bg/ba/addr 0, state IDLE. req_ready is 0 while reset is high and 1 in the first cycle after release.
- Handshake at edge a gives:
  - ACT at cycle a+1
  - CAS at a+1+T_RCD
  - PRE cycle at a+1+T_RCD+BL (+T_WR for writes)
  - done and req_ready at PRE+T_RP
- Back-to-back: with req_valid held, the next handshake occurs on the done cycle and its ACT follows on the next cycle.
- Reset mid-operation clears state and strobes immediately. No PR is issued for the aborted row.
- The delay counter is sized $clog2(max(T_RCD, BL+T_WR, T_RP)+1). It loads on each state entry, counts down to 0 and never wraps.

## Structure
- Package ddr_cmd_pkg holds:
  - the state enum
  - a command-kind enum (CMD_NONE, CMD_ACT, CMD_RD, CMD_RDA, CMD_WR, CMD_WRA, CMD_PR)
  - default timing constants shared with the timing benches
- Sub-module cmd_delay_counter: load value and load strobe in, zero flag out. The top-level FSM instantiates it once.

## Test plan
- Read, no AP, handshake at cycle 0 → ACT@1 (addr = row), RD@16 (addr = col), PR@24, done and req_ready@39; bg/ba stable from 1 to 38.
- Write, no AP → ACT@1, WR@16, PR@36, done@51.
- Read with AP → ACT@1, RDA@16, no PR strobe at any cycle, done@39. Same for WRA: WRA@16, done@51.
- Back-to-back: two reads with req_valid held → second handshake@39, second ACT@40; req_valid pulses during 1..38 are ignored.
- Reset asserted at cycle 10 (in WAIT_RCD) → strobes 0 immediately, no RD or PR ever issued. After release, req_ready = 1 and a new request yields ACT one cycle after its handshake.
- Parameter sweep BL = 4, T_WR = 0, T_RCD = 1: write handshake@0 → ACT@1, WR@2, PR@6, done@21. A checker asserts at most one strobe per cycle throughout.

Source files
------------

// File: rtl/ddr_cmd_pkg.sv
// ddr_cmd_pkg: shared types and default timing for the DDR command sequencer.
//   state_t  - sequencer FSM states
//   cmd_t    - kind of command strobe issued in a cycle
//   DEF_*    - default timing constants shared with the timing benches
package ddr_cmd_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ACT,
        S_WAIT_RCD,
        S_CAS,
        S_BURST,
        S_WAIT_WR,
        S_PRE,
        S_WAIT_RP
    } state_t;

    typedef enum logic [2:0] {
        CMD_NONE,
        CMD_ACT,
        CMD_RD,
        CMD_RDA,
        CMD_WR,
        CMD_WRA,
        CMD_PR
    } cmd_t;

    localparam int unsigned DEF_BGWIDTH  = 2;
    localparam int unsigned DEF_BAWIDTH  = 2;
    localparam int unsigned DEF_ROWWIDTH = 16;
    localparam int unsigned DEF_COLWIDTH = 10;
    localparam int unsigned DEF_BL       = 8;
    localparam int unsigned DEF_T_RCD    = 15;
    localparam int unsigned DEF_T_WR     = 12;
    localparam int unsigned DEF_T_RP     = 15;

endpackage

// File: rtl/cmd_delay_counter.sv
// cmd_delay_counter: loadable down-counter that saturates at zero.
//   clk, reset        - clock, async active-high reset
//   load, load_val    - load strobe and value (load wins over counting)
//   zero              - high while the count is zero
module cmd_delay_counter #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic             zero
);

    logic [WIDTH-1:0] cnt;

    // Count down to zero and hold there; never wraps.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt != '0) begin
            cnt <= cnt - WIDTH'(1);
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/ddr_cmd_sequencer.sv
// ddr_cmd_sequencer: accepts one read/write request at a time and issues the
// ACT, RD/RDA/WR/WRA and PR strobes honouring tRCD, BL, tWR and tRP.
//   clk, reset                      - clock, async active-high reset
//   req_valid/req_ready             - request handshake (ready decoded from state)
//   req_write, req_ap               - direction and auto-precharge select
//   req_bg, req_ba, req_row, req_col- request address fields
//   bg, ba, addr                    - registered address for the current command
//   ACT, RD, RDA, WR, WRA, PR       - registered one-cycle command strobes
//   done                            - registered pulse on the first idle cycle after a request
module ddr_cmd_sequencer
    import ddr_cmd_pkg::*;
#(
    parameter int unsigned BGWIDTH  = DEF_BGWIDTH,
    parameter int unsigned BAWIDTH  = DEF_BAWIDTH,
    parameter int unsigned ROWWIDTH = DEF_ROWWIDTH,
    parameter int unsigned COLWIDTH = DEF_COLWIDTH,
    parameter int unsigned BL       = DEF_BL,
    parameter int unsigned T_RCD    = DEF_T_RCD,
    parameter int unsigned T_WR     = DEF_T_WR,
    parameter int unsigned T_RP     = DEF_T_RP
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_write,
    input  logic                req_ap,
    input  logic [BGWIDTH-1:0]  req_bg,
    input  logic [BAWIDTH-1:0]  req_ba,
    input  logic [ROWWIDTH-1:0] req_row,
    input  logic [COLWIDTH-1:0] req_col,
    output logic [BGWIDTH-1:0]  bg,
    output logic [BAWIDTH-1:0]  ba,
    output logic [((ROWWIDTH > COLWIDTH) ? ROWWIDTH : COLWIDTH)-1:0] addr,
    output logic                ACT,
    output logic                RD,
    output logic                RDA,
    output logic                WR,
    output logic                WRA,
    output logic                PR,
    output logic                done
);

    localparam int unsigned ADDRWIDTH = (ROWWIDTH > COLWIDTH) ? ROWWIDTH : COLWIDTH;
    localparam int unsigned DMAX1     = (T_RCD > BL + T_WR) ? T_RCD : BL + T_WR;
    localparam int unsigned DMAX      = (DMAX1 > T_RP) ? DMAX1 : T_RP;
    localparam int unsigned CNTW      = $clog2(DMAX + 1);

    state_t              state, next_state;
    cmd_t                next_cmd;
    logic                hs;
    logic                cnt_load;
    logic [CNTW-1:0]     cnt_val;
    logic                cnt_zero;
    logic                hold_write;
    logic                hold_ap;
    logic [COLWIDTH-1:0] hold_col;

    assign req_ready = (state == S_IDLE) && !reset;
    assign hs        = req_valid && req_ready;

    cmd_delay_counter #(.WIDTH(CNTW)) u_dly (
        .clk      (clk),
        .reset    (reset),
        .load     (cnt_load),
        .load_val (cnt_val),
        .zero     (cnt_zero)
    );

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next state, delay-counter load on wait-state entry, and command for the next cycle.
    always_comb begin
        next_state = state;
        cnt_load   = 1'b0;
        cnt_val    = '0;
        next_cmd   = CMD_NONE;

        case (state)
            S_IDLE:     if (hs) next_state = S_ACT;
            S_ACT:      next_state = (T_RCD > 1) ? S_WAIT_RCD : S_CAS;
            S_WAIT_RCD: if (cnt_zero) next_state = S_CAS;
            S_CAS:      next_state = S_BURST;
            S_BURST:    if (cnt_zero) next_state = (hold_write && (T_WR > 0)) ? S_WAIT_WR : S_PRE;
            S_WAIT_WR:  if (cnt_zero) next_state = S_PRE;
            S_PRE:      next_state = (T_RP > 1) ? S_WAIT_RP : S_IDLE;
            S_WAIT_RP:  if (cnt_zero) next_state = S_IDLE;
            default:    next_state = S_IDLE;
        endcase

        // Loaded value is (cycles in state - 1); the state exits when the count hits zero.
        if (next_state != state) begin
            case (next_state)
                S_WAIT_RCD: begin cnt_load = 1'b1; cnt_val = CNTW'(T_RCD - 2); end
                S_BURST:    begin cnt_load = 1'b1; cnt_val = CNTW'(BL - 2);    end
                S_WAIT_WR:  begin cnt_load = 1'b1; cnt_val = CNTW'(T_WR - 1);  end
                S_WAIT_RP:  begin cnt_load = 1'b1; cnt_val = CNTW'(T_RP - 2);  end
                default:    ;
            endcase
        end

        case (next_state)
            S_ACT:   next_cmd = CMD_ACT;
            S_CAS:   next_cmd = hold_write ? (hold_ap ? CMD_WRA : CMD_WR)
                                           : (hold_ap ? CMD_RDA : CMD_RD);
            S_PRE:   next_cmd = hold_ap ? CMD_NONE : CMD_PR;
            default: next_cmd = CMD_NONE;
        endcase
    end

    // Registered strobes and address; ACT is only ever entered on a handshake,
    // so the row comes straight from the request inputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ACT        <= 1'b0;
            RD         <= 1'b0;
            RDA        <= 1'b0;
            WR         <= 1'b0;
            WRA        <= 1'b0;
            PR         <= 1'b0;
            done       <= 1'b0;
            bg         <= '0;
            ba         <= '0;
            addr       <= '0;
            hold_write <= 1'b0;
            hold_ap    <= 1'b0;
            hold_col   <= '0;
        end else begin
            ACT  <= (next_cmd == CMD_ACT);
            RD   <= (next_cmd == CMD_RD);
            RDA  <= (next_cmd == CMD_RDA);
            WR   <= (next_cmd == CMD_WR);
            WRA  <= (next_cmd == CMD_WRA);
            PR   <= (next_cmd == CMD_PR);
            done <= (state != S_IDLE) && (next_state == S_IDLE);

            case (next_cmd)
                CMD_ACT:                         addr <= ADDRWIDTH'(req_row);
                CMD_RD, CMD_RDA, CMD_WR, CMD_WRA: addr <= ADDRWIDTH'(hold_col);
                default:                         addr <= '0;
            endcase

            if (hs) begin
                bg         <= req_bg;
                ba         <= req_ba;
                hold_write <= req_write;
                hold_ap    <= req_ap;
                hold_col   <= req_col;
            end else if (next_state == S_IDLE) begin
                bg <= '0;
                ba <= '0;
            end
        end
    end

endmodule

// File: tb/tb_ddr_cmd_sequencer.sv
module tb_ddr_cmd_sequencer;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // DUT a: default parameters
    logic        a_valid, a_ready, a_write, a_ap;
    logic [1:0]  a_rbg, a_rba, a_bg, a_ba;
    logic [15:0] a_row, a_addr;
    logic [9:0]  a_col;
    logic        a_act, a_rd, a_rda, a_wr, a_wra, a_pr, a_done;

    // DUT b: BL=4, T_WR=0, T_RCD=1
    logic        b_valid, b_ready, b_write, b_ap;
    logic [1:0]  b_rbg, b_rba, b_bg, b_ba;
    logic [15:0] b_row, b_addr;
    logic [9:0]  b_col;
    logic        b_act, b_rd, b_rda, b_wr, b_wra, b_pr, b_done;

    int tests = 0;
    int fails = 0;
    int onehot_err = 0;

    ddr_cmd_sequencer dut_a (
        .clk(clk), .reset(rst), .req_valid(a_valid), .req_ready(a_ready),
        .req_write(a_write), .req_ap(a_ap), .req_bg(a_rbg), .req_ba(a_rba),
        .req_row(a_row), .req_col(a_col), .bg(a_bg), .ba(a_ba), .addr(a_addr),
        .ACT(a_act), .RD(a_rd), .RDA(a_rda), .WR(a_wr), .WRA(a_wra), .PR(a_pr),
        .done(a_done)
    );

    ddr_cmd_sequencer #(.BL(4), .T_WR(0), .T_RCD(1)) dut_b (
        .clk(clk), .reset(rst), .req_valid(b_valid), .req_ready(b_ready),
        .req_write(b_write), .req_ap(b_ap), .req_bg(b_rbg), .req_ba(b_rba),
        .req_row(b_row), .req_col(b_col), .bg(b_bg), .ba(b_ba), .addr(b_addr),
        .ACT(b_act), .RD(b_rd), .RDA(b_rda), .WR(b_wr), .WRA(b_wra), .PR(b_pr),
        .done(b_done)
    );

    // At most one strobe per cycle on either instance.
    always @(negedge clk) begin
        if ($countones({a_act, a_rd, a_rda, a_wr, a_wra, a_pr}) > 1) onehot_err++;
        if ($countones({b_act, b_rd, b_rda, b_wr, b_wra, b_pr}) > 1) onehot_err++;
    end

    // Present a request to DUT a and complete the handshake on the next rising edge (edge 0).
    task automatic launch_a(input logic wr, input logic ap, input logic [1:0] rbg,
                            input logic [1:0] rba, input logic [15:0] row, input logic [9:0] col);
        int waited = 0;
        @(negedge clk);
        while (!a_ready && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        tests++;
        if (a_ready !== 1'b1) begin
            fails++;
            $display("FAIL launch_ready: req_ready=%b, required 1", a_ready);
        end
        a_valid = 1'b1; a_write = wr; a_ap = ap;
        a_rbg = rbg; a_rba = rba; a_row = row; a_col = col;
        @(posedge clk);
        #1;
        a_valid = 1'b0;
        a_row = 16'h0; a_col = 10'h0; a_rbg = 2'b0; a_rba = 2'b0;
    endtask

    // Record first cycle of each strobe (relative to edge 0) until done.
    task automatic observe_a(input int max_k, input logic [1:0] ebg, input logic [1:0] eba,
                             output int t_act, output int t_cas, output int cas_k,
                             output int t_pr, output int t_done,
                             output logic [15:0] ad_act, output logic [15:0] ad_cas,
                             output bit bgba_ok, output logic rdy_done);
        t_act = -1; t_cas = -1; cas_k = 0; t_pr = -1; t_done = -1;
        ad_act = 16'hxxxx; ad_cas = 16'hxxxx; bgba_ok = 1'b1; rdy_done = 1'b0;
        for (int k = 1; k <= max_k; k++) begin
            @(negedge clk);
            if (a_act && t_act < 0) begin t_act = k; ad_act = a_addr; end
            if ((a_rd | a_rda | a_wr | a_wra) && t_cas < 0) begin
                t_cas = k; ad_cas = a_addr;
                cas_k = a_rd ? 1 : (a_rda ? 2 : (a_wr ? 3 : 4));
            end
            if (a_pr && t_pr < 0) t_pr = k;
            if (a_done) begin
                t_done = k; rdy_done = a_ready;
                if (a_bg !== 2'b00 || a_ba !== 2'b00) bgba_ok = 1'b0;
                break;
            end else if (a_bg !== ebg || a_ba !== eba) begin
                bgba_ok = 1'b0;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        a_valid = 1'b0; a_write = 1'b0; a_ap = 1'b0; a_rbg = 2'b0; a_rba = 2'b0; a_row = 16'h0; a_col = 10'h0;
        b_valid = 1'b0; b_write = 1'b0; b_ap = 1'b0; b_rbg = 2'b0; b_rba = 2'b0; b_row = 16'h0; b_col = 10'h0;
        repeat (3) @(negedge clk);
        tests++;
        if ({a_act, a_rd, a_rda, a_wr, a_wra, a_pr, a_done} !== 7'b0) begin
            fails++; $display("FAIL reset_strobes: got %b, required 0", {a_act, a_rd, a_rda, a_wr, a_wra, a_pr, a_done});
        end
        tests++;
        if ({a_bg, a_ba, a_addr} !== 20'h0) begin
            fails++; $display("FAIL reset_addr: got %h, required 0", {a_bg, a_ba, a_addr});
        end
        tests++;
        if (a_ready !== 1'b0) begin
            fails++; $display("FAIL reset_ready_low: got %b, required 0", a_ready);
        end
        rst = 1'b0;
        #1;
        tests++;
        if (a_ready !== 1'b1 || b_ready !== 1'b1) begin
            fails++; $display("FAIL reset_ready_release: a=%b b=%b, required 1", a_ready, b_ready);
        end
    endtask

    task automatic test_read();
        int t_act, t_cas, cas_k, t_pr, t_done;
        logic [15:0] ad_act, ad_cas;
        bit bgba_ok;
        logic rdy;
        launch_a(1'b0, 1'b0, 2'd2, 2'd1, 16'hBEEF, 10'h2A5);
        observe_a(80, 2'd2, 2'd1, t_act, t_cas, cas_k, t_pr, t_done, ad_act, ad_cas, bgba_ok, rdy);
        tests++;
        if (t_act !== 1 || ad_act !== 16'hBEEF) begin
            fails++; $display("FAIL read_act: cycle %0d addr %h, required 1 BEEF", t_act, ad_act);
        end
        tests++;
        if (t_cas !== 16 || cas_k !== 1 || ad_cas !== 16'h02A5) begin
            fails++; $display("FAIL read_cas: cycle %0d kind %0d addr %h, required 16 1 02A5", t_cas, cas_k, ad_cas);
        end
        tests++;
        if (t_pr !== 24) begin
            fails++; $display("FAIL read_pr: cycle %0d, required 24", t_pr);
        end
        tests++;
        if (t_done !== 39 || rdy !== 1'b1) begin
            fails++; $display("FAIL read_done: cycle %0d ready %b, required 39 1", t_done, rdy);
        end
        tests++;
        if (!bgba_ok) begin
            fails++; $display("FAIL read_bgba: bg/ba not held at 2/1 over 1..38, got 0, required 1");
        end
    endtask

    task automatic test_write();
        int t_act, t_cas, cas_k, t_pr, t_done;
        logic [15:0] ad_act, ad_cas;
        bit bgba_ok;
        logic rdy;
        launch_a(1'b1, 1'b0, 2'd1, 2'd3, 16'h1234, 10'h3FF);
        observe_a(80, 2'd1, 2'd3, t_act, t_cas, cas_k, t_pr, t_done, ad_act, ad_cas, bgba_ok, rdy);
        tests++;
        if (t_act !== 1 || ad_act !== 16'h1234) begin
            fails++; $display("FAIL write_act: cycle %0d addr %h, required 1 1234", t_act, ad_act);
        end
        tests++;
        if (t_cas !== 16 || cas_k !== 3 || ad_cas !== 16'h03FF) begin
            fails++; $display("FAIL write_cas: cycle %0d kind %0d addr %h, required 16 3 03FF", t_cas, cas_k, ad_cas);
        end
        tests++;
        if (t_pr !== 36) begin
            fails++; $display("FAIL write_pr: cycle %0d, required 36", t_pr);
        end
        tests++;
        if (t_done !== 51 || rdy !== 1'b1 || !bgba_ok) begin
            fails++; $display("FAIL write_done: cycle %0d ready %b bgba %b, required 51 1 1", t_done, rdy, bgba_ok);
        end
    endtask

    task automatic test_auto_precharge();
        int t_act, t_cas, cas_k, t_pr, t_done;
        logic [15:0] ad_act, ad_cas;
        bit bgba_ok;
        logic rdy;
        for (int w = 0; w < 2; w++) begin
            launch_a(w[0], 1'b1, 2'd3, 2'd2, 16'h0F0F, 10'h155);
            observe_a(80, 2'd3, 2'd2, t_act, t_cas, cas_k, t_pr, t_done, ad_act, ad_cas, bgba_ok, rdy);
            tests++;
            if (t_act !== 1 || t_cas !== 16 || cas_k !== (w == 0 ? 2 : 4)) begin
                fails++; $display("FAIL ap_cas w=%0d: act %0d cas %0d kind %0d, required 1 16 %0d",
                                  w, t_act, t_cas, cas_k, (w == 0 ? 2 : 4));
            end
            tests++;
            if (t_pr !== -1) begin
                fails++; $display("FAIL ap_no_pr w=%0d: PR at cycle %0d, required none (-1)", w, t_pr);
            end
            tests++;
            if (t_done !== (w == 0 ? 39 : 51)) begin
                fails++; $display("FAIL ap_done w=%0d: cycle %0d, required %0d", w, t_done, (w == 0 ? 39 : 51));
            end
        end
    endtask

    task automatic test_back_to_back();
        int act1 = -1, act2 = -1, hs2 = -1, acts_between = 0, t_done2 = -1;
        @(negedge clk);
        a_valid = 1'b1; a_write = 1'b0; a_ap = 1'b0;
        a_rbg = 2'd0; a_rba = 2'd0; a_row = 16'h00AA; a_col = 10'h011;
        @(posedge clk);
        for (int k = 1; k <= 45; k++) begin
            @(negedge clk);
            if (a_act) begin
                if (act1 < 0) act1 = k;
                else if (act2 < 0) act2 = k;
                if (k > 1 && k < 40) acts_between++;
            end
            if (a_ready && a_valid && hs2 < 0) hs2 = k;
            if (act2 > 0) begin
                a_valid = 1'b0;
                break;
            end
        end
        a_valid = 1'b0;
        for (int k = 1; k <= 60; k++) begin
            @(negedge clk);
            if (a_done) begin t_done2 = k; break; end
        end
        tests++;
        if (act1 !== 1 || hs2 !== 39 || act2 !== 40) begin
            fails++; $display("FAIL b2b_timing: act1 %0d hs2 %0d act2 %0d, required 1 39 40", act1, hs2, act2);
        end
        tests++;
        if (acts_between !== 0) begin
            fails++; $display("FAIL b2b_ignored: %0d extra ACTs while busy, required 0", acts_between);
        end
        tests++;
        if (t_done2 !== 38) begin
            fails++; $display("FAIL b2b_done2: %0d cycles after second ACT, required 38", t_done2);
        end
    endtask

    task automatic test_reset_mid();
        int bad = 0;
        int t_act, t_cas, cas_k, t_pr, t_done;
        logic [15:0] ad_act, ad_cas;
        bit bgba_ok;
        logic rdy;
        launch_a(1'b0, 1'b0, 2'd1, 2'd1, 16'h5555, 10'h0AA);
        repeat (10) @(negedge clk);
        rst = 1'b1;
        #1;
        tests++;
        if ({a_act, a_rd, a_rda, a_wr, a_wra, a_pr, a_done, a_ready} !== 8'b0 || {a_bg, a_ba} !== 4'b0) begin
            fails++; $display("FAIL midreset_clear: strobes/ready %b bgba %b, required 0",
                              {a_act, a_rd, a_rda, a_wr, a_wra, a_pr, a_done, a_ready}, {a_bg, a_ba});
        end
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (a_rd | a_pr) bad++;
        end
        rst = 1'b0;
        #1;
        tests++;
        if (a_ready !== 1'b1) begin
            fails++; $display("FAIL midreset_ready: got %b, required 1", a_ready);
        end
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (a_rd | a_pr) bad++;
        end
        tests++;
        if (bad !== 0) begin
            fails++; $display("FAIL midreset_no_cmd: %0d RD/PR seen after abort, required 0", bad);
        end
        launch_a(1'b0, 1'b0, 2'd0, 2'd2, 16'h7777, 10'h001);
        observe_a(80, 2'd0, 2'd2, t_act, t_cas, cas_k, t_pr, t_done, ad_act, ad_cas, bgba_ok, rdy);
        tests++;
        if (t_act !== 1 || ad_act !== 16'h7777 || t_done !== 39) begin
            fails++; $display("FAIL midreset_recover: act %0d addr %h done %0d, required 1 7777 39", t_act, ad_act, t_done);
        end
    endtask

    task automatic test_param_sweep();
        int t_act = -1, t_wr = -1, t_pr = -1, t_done = -1;
        logic [15:0] ad_wr = 16'hxxxx;
        @(negedge clk);
        b_valid = 1'b1; b_write = 1'b1; b_ap = 1'b0;
        b_rbg = 2'd1; b_rba = 2'd2; b_row = 16'hCAFE; b_col = 10'h123;
        @(posedge clk);
        #1;
        b_valid = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (b_act && t_act < 0) t_act = k;
            if (b_wr && t_wr < 0) begin t_wr = k; ad_wr = b_addr; end
            if (b_pr && t_pr < 0) t_pr = k;
            if (b_done) begin t_done = k; break; end
        end
        tests++;
        if (t_act !== 1 || t_wr !== 2 || ad_wr !== 16'h0123) begin
            fails++; $display("FAIL sweep_act_wr: act %0d wr %0d addr %h, required 1 2 0123", t_act, t_wr, ad_wr);
        end
        tests++;
        if (t_pr !== 6 || t_done !== 21) begin
            fails++; $display("FAIL sweep_pr_done: pr %0d done %0d, required 6 21", t_pr, t_done);
        end
    endtask

    initial begin
        test_reset();
        test_read();
        test_write();
        test_auto_precharge();
        test_back_to_back();
        test_reset_mid();
        test_param_sweep();
        repeat (2) @(negedge clk);
        tests++;
        if (onehot_err !== 0) begin
            fails++; $display("FAIL one_strobe: %0d cycles with multiple strobes, required 0", onehot_err);
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
